multicycle_control_unit: RTL and testbench

- Multi-cycle FSM controller that sequences the 64-bit RV64 load/store/ALU/branch datapath.
- Fetches a 32-bit instruction over a req/valid handshake and holds it in an internal IR.
- Drives the register addresses, immediate, mux selects, ALU add/sub, funct3 and write enables.
- Owns the PC and updates it from the datapath's selectedFlag on branches.

---
 rtl/multicycle_control_unit_pkg.sv | 62 ++++++
 rtl/multicycle_control_unit_imm_gen.sv | 33 +++
 rtl/multicycle_control_unit.sv | 119 +++++++++++
 tb/tb_multicycle_control_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the RV64 multi-cycle controller:
// opcodes, funct codes, FSM states and the instruction classifier.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_LD_SD   = 3'b011;
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_BNE     = 3'b001;
   localparam logic [2:0] F3_BLT     = 3'b100;
   localparam logic [2:0] F3_BGE     = 3'b101;
   localparam logic [2:0] F3_BLTU    = 3'b110;
   localparam logic [2:0] F3_BGEU    = 3'b111;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, WB, HALT
   } state_t;

   typedef enum logic [2:0] {
      K_ILLEGAL, K_LOAD, K_STORE, K_ADDI,
      K_ADD, K_SUB, K_BRANCH
   } kind_t;

   function automatic kind_t decodeKind(input logic [31:0] ir);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      kind_t      k;
      op = ir[6:0];
      f3 = ir[14:12];
      f7 = ir[31:25];
      k  = K_ILLEGAL;
      unique case (1'b1)
         (op == OP_LOAD):
            if (f3 == F3_LD_SD) k = K_LOAD;
         (op == OP_STORE):
            if (f3 == F3_LD_SD) k = K_STORE;
         (op == OP_IMM):
            if (f3 == F3_ADD_SUB) k = K_ADDI;
         (op == OP_REG):
            if (f3 == F3_ADD_SUB) begin
               if (f7 == F7_ADD)      k = K_ADD;
               else if (f7 == F7_SUB) k = K_SUB;
            end
         (op == OP_BRANCH):
            if (f3 inside {F3_BEQ, F3_BNE, F3_BLT,
                           F3_BGE, F3_BLTU, F3_BGEU})
               k = K_BRANCH;
         default: k = K_ILLEGAL;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_imm_gen.sv
// Immediate generator: sign-extends the I/S/B immediate
// selected by the IR opcode; everything else yields zero.
module imm_gen
   import riscv_ctrl_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     ir,
   output logic [XLEN-1:0] immediate
);

   // funct3 and rs1 never feed an immediate
   logic unusedFields;
   assign unusedFields = ^ir[19:12];

   // pick the immediate layout from the opcode
   always_comb begin
      immediate = '0;
      unique case (1'b1)
         (ir[6:0] == OP_LOAD),
         (ir[6:0] == OP_IMM):
            immediate = {{(XLEN-12){ir[31]}}, ir[31:20]};
         (ir[6:0] == OP_STORE):
            immediate = {{(XLEN-12){ir[31]}},
                         ir[31:25], ir[11:7]};
         (ir[6:0] == OP_BRANCH):
            immediate = {{(XLEN-13){ir[31]}}, ir[31],
                         ir[7], ir[30:25], ir[11:8], 1'b0};
         default: immediate = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM controller for the RV64 load/store/ALU/branch
// datapath: fetches into IR, owns the PC, drives Moore controls.
module multicycle_control_unit
   import riscv_ctrl_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            instr_req,
   output logic [XLEN-1:0] instr_addr,
   input  logic            instr_valid,
   input  logic [31:0]     instr,
   input  logic            selectedFlag,
   output logic [XLEN-1:0] immediate,
   output logic [4:0]      readRegister1,
   output logic [4:0]      readRegister2,
   output logic [4:0]      writeRegister,
   output logic [2:0]      funct3,
   output logic            writeEnable_DataMemory,
   output logic            writeEnable_Registers,
   output logic            muxSelect_SumVsReadData,
   output logic            muxSelect_ImmVsDataout2,
   output logic            SumOrSub,
   output logic            halted,
   output logic            illegal
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [31:0]     ir;
   logic            illegalQ;
   kind_t           kind;
   logic            aluPhase;

   assign kind = decodeKind(ir);

   imm_gen #(.XLEN(XLEN)) uImmGen (
      .ir        (ir),
      .immediate (immediate)
   );

   // sequencer: state, IR capture, PC update and sticky illegal flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH;
         pc       <= RESET_PC;
         ir       <= '0;
         illegalQ <= 1'b0;
      end else begin
         unique case (state)
            FETCH:
               if (instr_valid) begin
                  ir    <= instr;
                  state <= DECODE;
               end
            DECODE:
               if (kind == K_ILLEGAL) begin
                  illegalQ <= 1'b1;
                  state    <= HALT;
               end else begin
                  state <= EXEC;
               end
            EXEC:
               unique case (kind)
                  K_BRANCH: begin
                     pc    <= selectedFlag ? pc + immediate
                                           : pc + PC_STEP;
                     state <= FETCH;
                  end
                  K_LOAD, K_STORE: state <= MEM;
                  default:         state <= WB;
               endcase
            MEM:
               if (kind == K_STORE) begin
                  pc    <= pc + PC_STEP;
                  state <= FETCH;
               end else begin
                  state <= WB;
               end
            WB: begin
               pc    <= pc + PC_STEP;
               state <= FETCH;
            end
            HALT:    state <= HALT;
            default: state <= HALT;
         endcase
      end
   end

   assign aluPhase = (state == EXEC) || (state == MEM) ||
                     (state == WB);

   assign instr_req  = (state == FETCH);
   assign instr_addr = pc;
   assign halted     = (state == HALT);
   assign illegal    = illegalQ;

   assign readRegister1 = ir[19:15];
   assign readRegister2 = ir[24:20];
   assign writeRegister = ir[11:7];
   assign funct3        = ir[14:12];

   assign SumOrSub = aluPhase &&
                     (kind == K_SUB || kind == K_BRANCH);
   assign muxSelect_ImmVsDataout2 = aluPhase &&
      (kind == K_ADDI || kind == K_LOAD || kind == K_STORE);

   assign writeEnable_DataMemory = (state == MEM) &&
                                   (kind == K_STORE);
   assign writeEnable_Registers  = (state == WB) &&
                                   (writeRegister != 5'd0);
   assign muxSelect_SumVsReadData = (state == WB) &&
                                    (kind == K_LOAD);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit against a
// per-instruction cycle model of fetch/decode/execute timing.
module tb_multicycle_control_unit;

   localparam logic [63:0] RST_PC = 64'h100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        selectedFlag = 1'b0;
   logic        instr_req, halted, illegal;
   logic [63:0] instr_addr, immediate;
   logic [4:0]  rs1, rs2, rd;
   logic [2:0]  f3;
   logic        weDM, weReg, muxSR, immSel, sub;
   logic [7:0]  ctl;

   int          nCmp = 0;
   int          nBad = 0;
   logic [63:0] pcModel = RST_PC;

   multicycle_control_unit #(
      .XLEN(64), .RESET_PC(RST_PC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_req(instr_req), .instr_addr(instr_addr),
      .instr_valid(instr_valid), .instr(instr),
      .selectedFlag(selectedFlag), .immediate(immediate),
      .readRegister1(rs1), .readRegister2(rs2),
      .writeRegister(rd), .funct3(f3),
      .writeEnable_DataMemory(weDM),
      .writeEnable_Registers(weReg),
      .muxSelect_SumVsReadData(muxSR),
      .muxSelect_ImmVsDataout2(immSel),
      .SumOrSub(sub), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   assign ctl = {instr_req, halted, weDM, weReg,
                 muxSR, immSel, sub, illegal};

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      nCmp++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // 0 illegal, 1 LD, 2 SD, 3 ADDI, 4 ADD, 5 SUB, 6 branch
   function automatic int classify(input logic [31:0] w);
      logic [6:0] op;
      logic [2:0] fn3;
      logic [6:0] fn7;
      op = w[6:0]; fn3 = w[14:12]; fn7 = w[31:25];
      if (op == 7'h03 && fn3 == 3'd3) return 1;
      if (op == 7'h23 && fn3 == 3'd3) return 2;
      if (op == 7'h13 && fn3 == 3'd0) return 3;
      if (op == 7'h33 && fn3 == 3'd0 && fn7 == 7'h00) return 4;
      if (op == 7'h33 && fn3 == 3'd0 && fn7 == 7'h20) return 5;
      if (op == 7'h63 && fn3 != 3'd2 && fn3 != 3'd3) return 6;
      return 0;
   endfunction

   function automatic logic [63:0] immOf(input logic [31:0] w,
                                         input int c);
      longint v;
      v = 0;
      if (c == 1 || c == 3) begin
         v = longint'(w[31:20]);
         if (w[31]) v = v - 4096;
      end else if (c == 2) begin
         v = longint'({w[31:25], w[11:7]});
         if (w[31]) v = v - 4096;
      end else if (c == 6) begin
         v = 2 * longint'({w[31], w[7], w[30:25], w[11:8]});
         if (w[31]) v = v - 8192;
      end
      return v;
   endfunction

   function automatic logic [31:0] encB(input logic [12:0] im,
      input logic [2:0] fn3, input logic [4:0] a,
      input logic [4:0] b);
      return {im[12], im[10:5], b, a, fn3, im[4:1], im[11], 7'h63};
   endfunction

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      instr_valid = 1'b0;
      #2;
      chk("rstCtl", ctl, 8'b1000_0000);
      chk("rstAddr", instr_addr, RST_PC);
      chk("rstFields", {rs1, rs2, rd, f3}, 0);
      chk("rstImm", immediate, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pcModel = RST_PC;
   endtask

   // runs one instruction from its first FETCH cycle to the next
   task automatic runInstr(input logic [31:0] w, input int delay,
                           input int flagForce);
      int   c, n;
      logic fl, last, alu, wr;
      c  = classify(w);
      fl = 1'b0;
      for (int d = 0; d <= delay; d++) begin
         chk("fetchCtl", ctl, 8'b1000_0000);
         chk("fetchAddr", instr_addr, pcModel);
         instr_valid = (d == delay);
         instr = (d == delay) ? w : $urandom;
         selectedFlag = 1'($urandom);
         @(negedge clk);
      end
      instr_valid = 1'b0;
      instr = $urandom;
      if (c == 0) begin
         chk("illDecode", ctl, 8'b0000_0000);
         @(negedge clk);
         for (int h = 0; h < 3; h++) begin
            instr_valid = 1'b1;
            chk("haltCtl", ctl, 8'b0100_0001);
            chk("haltPc", instr_addr, pcModel);
            @(negedge clk);
         end
         instr_valid = 1'b0;
         return;
      end
      n = (c == 6) ? 2 : (c == 1) ? 4 : 3;
      wr = (c == 1 || c == 3 || c == 4 || c == 5);
      for (int k = 1; k <= n; k++) begin
         last = (k == n);
         alu  = (k >= 2);
         chk("cycCtl", ctl, {2'b00, (c == 2) && last,
             wr && last && (w[11:7] != 5'd0),
             (c == 1) && last,
             alu && (c == 1 || c == 2 || c == 3),
             alu && (c == 5 || c == 6), 1'b0});
         chk("cycAddr", instr_addr, pcModel);
         if (k == 1) begin
            chk("fields", {rs1, rs2, rd, f3},
                {w[19:15], w[24:20], w[11:7], w[14:12]});
            chk("imm", immediate, immOf(w, c));
         end
         selectedFlag = (flagForce < 0) ? 1'($urandom)
                                        : flagForce[0];
         if (k == 2) fl = selectedFlag;
         @(negedge clk);
      end
      pcModel = (c == 6 && fl) ? pcModel + immOf(w, c)
                               : pcModel + 64'd4;
   endtask

   initial begin
      logic [31:0] w;
      logic [12:0] off;
      logic [4:0]  r;
      int          sel;

      doReset();
      runInstr(32'hFFD00293, 0, -1);
      chk("addiPc", instr_addr, 64'h104);
      runInstr(32'h0082B303, 1, -1);
      runInstr(32'h00208033, 0, -1);
      runInstr(32'h0062B823, 2, -1);
      runInstr(32'h40208133, 0, -1);
      off = 13'(64'h200 - pcModel);
      runInstr(encB(off, 3'd0, 5'd1, 5'd2), 0, 1);
      chk("toPc200", instr_addr, 64'h200);
      runInstr(32'hFE629CE3, 0, 1);
      chk("bneTaken", instr_addr, 64'h1F8);
      runInstr(encB(13'd8, 3'd0, 5'd3, 5'd4), 0, 1);
      runInstr(32'hFE629CE3, 1, 0);
      chk("bneNotTaken", instr_addr, 64'h204);
      runInstr(32'hFFFFFFFF, 0, -1);
      chk("illSticky", illegal, 1);
      doReset();
      runInstr(32'h00000073, 0, -1);
      doReset();

      // reset asserted while the WB strobe is high
      w = 32'h00500393;
      instr_valid = 1'b1;
      instr = w;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("wbStrobe", weReg, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("asyncDrop", ctl, 8'b1000_0000);
      chk("asyncPc", instr_addr, RST_PC);
      @(negedge clk);
      rst_n = 1'b1;
      pcModel = RST_PC;
      runInstr(w, 1, -1);
      chk("restartPc", instr_addr, RST_PC + 64'd4);

      for (int i = 0; i < 300; i++) begin
         r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         w = $urandom;
         sel = $urandom_range(0, 12);
         case (sel)
            0, 1: w = {w[31:15], 3'd3, r, 7'h03};
            2, 3: w = {w[31:15], 3'd3, w[11:7], 7'h23};
            4, 5: w = {w[31:15], 3'd0, r, 7'h13};
            6:    w = {7'h00, w[24:15], 3'd0, r, 7'h33};
            7:    w = {7'h20, w[24:15], 3'd0, r, 7'h33};
            8, 9, 10: begin
               w[6:0] = 7'h63;
               while (w[14:13] == 2'b01) w[14:12] = 3'($urandom);
            end
            11: ;
            default: begin
               while (classify(w) != 0) w = $urandom;
            end
         endcase
         runInstr(w, $urandom_range(0, 3), -1);
         if (classify(w) == 0) doReset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               nCmp, nBad);
      $finish;
   end

endmodule
